// File: rtl/bcd_stopwatch_counter.sv
// rtl/bcd_stopwatch_counter.sv - 4-digit BCD stopwatch time base with prescaler, lap lock and wrap pulse
module bcd_stopwatch_counter #(
    parameter int DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        clear,
    input  logic        lap,
    output logic [15:0] count,
    output logic        lock,
    output logic        running,
    output logic        overflow
);

    localparam int            PW      = $clog2(DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE
    } state_t;

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic [15:0]   count_q;
    logic          lock_q;
    logic          running_q;
    logic          overflow_q;

    logic [15:0]   count_d;
    logic          carry;

    // BCD ripple: a digit at 9 rolls to 0 and passes the carry upward.
    always_comb begin
        count_d = count_q;
        carry   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (count_q[i*4 +: 4] == 4'd9) begin
                    count_d[i*4 +: 4] = 4'd0;
                end else begin
                    count_d[i*4 +: 4] = count_q[i*4 +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            count_q    <= '0;
            lock_q     <= 1'b0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    lock_q <= 1'b0;
                    if (start_stop) begin
                        state_q   <= RUN;
                        presc_q   <= '0;
                        running_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (lap) lock_q <= ~lock_q;
                    // A pause on the terminal prescaler value suppresses the tick.
                    if (start_stop) begin
                        state_q   <= PAUSE;
                        running_q <= 1'b0;
                    end else if (presc_q == PRE_MAX) begin
                        presc_q    <= '0;
                        count_q    <= count_d;
                        overflow_q <= carry;
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                PAUSE: begin
                    if (clear) begin
                        state_q <= IDLE;
                        count_q <= '0;
                        presc_q <= '0;
                        lock_q  <= 1'b0;
                    end else begin
                        if (lap) lock_q <= ~lock_q;
                        if (start_stop) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign count    = count_q;
    assign lock     = lock_q;
    assign running  = running_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// tb/tb_bcd_stopwatch_counter.sv - randomized and directed check of bcd_stopwatch_counter against a behavioural model
module tb_bcd_stopwatch_counter;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        clear = 1'b0;
    logic        lap = 1'b0;
    logic [15:0] count;
    logic        lock;
    logic        running;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    // Model: state 0=idle 1=run 2=pause, count held as a plain integer.
    int m_state = 0;
    int m_cnt   = 0;
    int m_pre   = 0;
    bit m_lock  = 0;
    bit m_ovf   = 0;

    bcd_stopwatch_counter #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_stop(start_stop),
        .clear     (clear),
        .lap       (lap),
        .count     (count),
        .lock      (lock),
        .running   (running),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [3:0] d3, d2, d1, d0;
        d3 = 4'(n / 1000);
        d2 = 4'((n / 100) % 10);
        d1 = 4'((n / 10) % 10);
        d0 = 4'(n % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic model_reset();
        m_state = 0; m_cnt = 0; m_pre = 0; m_lock = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit ss, input bit cl, input bit lp);
        m_ovf = 0;
        case (m_state)
            0: begin
                m_lock = 0;
                if (ss) begin m_state = 1; m_pre = 0; end
            end
            1: begin
                if (lp) m_lock = !m_lock;
                if (ss) m_state = 2;
                else if (m_pre == DIV - 1) begin
                    m_pre = 0;
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 10000) begin m_cnt = 0; m_ovf = 1; end
                end else m_pre = m_pre + 1;
            end
            default: begin
                if (cl) begin m_state = 0; m_cnt = 0; m_pre = 0; m_lock = 0; end
                else begin
                    if (lp) m_lock = !m_lock;
                    if (ss) m_state = 1;
                end
            end
        endcase
    endtask

    task automatic check_outputs();
        check("count", 32'(count), 32'(to_bcd(m_cnt)));
        check("lock", 32'(lock), 32'(m_lock));
        check("running", 32'(running), 32'(m_state == 1));
        check("overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Called just after a falling edge; drives one cycle of inputs and checks at the next falling edge.
    task automatic step(input bit ss, input bit cl, input bit lp);
        start_stop = ss; clear = cl; lap = lp;
        @(posedge clk);
        model_step(ss, cl, lp);
        @(negedge clk);
        start_stop = 0; clear = 0; lap = 0;
        check_outputs();
    endtask

    task automatic run_to(input int target, input int limit);
        int n = 0;
        while (m_cnt != target && n < limit) begin
            step(0, 0, 0);
            n++;
        end
        check("run_to_reached", 32'(m_cnt), 32'(target));
    endtask

    initial begin
        #2;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Start latency and early counts
        step(1, 0, 0);
        check("running_after_start", 32'(running), 32'd1);
        for (int i = 0; i < 40; i++) step(0, 0, 0);
        check("count_after_40", 32'(count), 32'h0010);

        // Async reset mid-RUN at 0123
        run_to(123, 2000);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_count", 32'(count), 32'h0000);
        check("rst_lock", 32'(lock), 32'd0);
        check("rst_running", 32'(running), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs();

        // Pause at 0007, hold, resume, clear ignored in RUN, pause + clear
        step(1, 0, 0);
        run_to(7, 200);
        step(1, 0, 0);
        for (int i = 0; i < 20; i++) step(0, 0, 0);
        check("held_at_7", 32'(count), 32'h0007);
        step(1, 0, 0);
        step(0, 1, 0);
        run_to(9, 200);
        step(1, 0, 0);
        step(0, 1, 0);
        check("cleared", 32'(count), 32'h0000);
        check("idle_after_clear", 32'(running), 32'd0);

        // Pause exactly on the terminal prescaler value, then resume
        step(1, 0, 0);
        while (m_pre != DIV - 1) step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("resume_tick", 32'(count), 32'(to_bcd(m_cnt)));
        step(1, 0, 0);
        step(0, 1, 0);

        // Lap behaviour
        step(1, 0, 0);
        run_to(42, 400);
        step(0, 0, 1);
        check("lap_lock", 32'(lock), 32'd1);
        run_to(50, 100);
        step(0, 0, 1);
        check("lap_release", 32'(lock), 32'd0);
        step(1, 0, 1);
        step(0, 1, 0);
        step(0, 0, 1);
        check("lap_idle", 32'(lock), 32'd0);

        // Simultaneous controls
        step(1, 0, 0);
        run_to(3, 100);
        step(1, 1, 0);
        check("ss_clr_run", 32'(running), 32'd0);
        step(0, 0, 0);
        check("ss_clr_run_count", 32'(count), 32'h0003);
        step(1, 1, 0);
        check("ss_clr_pause", 32'(count), 32'h0000);

        // Wrap 9999 -> 0000
        step(1, 0, 0);
        run_to(9999, 45000);
        while (m_pre != DIV - 1) step(0, 0, 0);
        step(0, 0, 0);
        check("wrap_overflow", 32'(overflow), 32'd1);
        step(0, 0, 0);
        check("wrap_overflow_1clk", 32'(overflow), 32'd0);
        for (int i = 0; i < 10; i++) step(0, 0, 0);

        // Randomized control pulses
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 11) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 9) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
